pipelined_control: RTL and testbench
====================================

Name: pipelined_control

Overview:
- Registered, handshaked successor to the combinational control decoder.
- Accepts one machine-code word per cycle from fetch and presents a registered control bundle to the datapath one cycle later.
- Stretches loads over a parametrised memory latency and supports datapath-driven flush.
- Decodes the full opcode space, including loadi, pari and illegal opcodes, and keeps a saturating illegal-opcode counter.

Parameters:
MCODEBITS, 9, machine-code width; opcode is Instr[MCODEBITS-1 -: OPCODEBITS]
OPCODEBITS, 4, opcode field width (>=4; upper bits beyond 4 must be zero, else illegal)
OPWIDTH, 3, ALUOp width (>=3; codes zero-extended)
LOAD_LAT, 2, cycles a load bundle is held (1..15)
CNTW, 8, width of illegal-opcode counter

Ports:
Clk  in  1  clock, rising edge
Reset_n  in  1  asynchronous active-low reset
Instr  in  MCODEBITS  instruction word
InstrValid  in  1  Instr is valid
InstrReady  out  1  decoder accepts Instr this cycle
Flush  in  1  synchronous kill of the held bundle (taken branch)
CtrlValid  out  1  control bundle valid
RegDst, Branch, MemtoReg, MemWrite, ALUSrc, RegWrite  out  1 each  control strobes
ImmLoad  out  1  loadi: write immediate to register
Parity  out  1  pari: datapath selects parity result
ALUOp  out  OPWIDTH  ALU operation
Illegal  out  1  held bundle came from an illegal opcode
Busy  out  1  load stretch in progress
IllegalCount  out  CNTW  saturating count of accepted illegal opcodes

Behaviour:
- Reset (async, Reset_n=0): all strobes, ImmLoad, Parity, Illegal, CtrlValid and Busy = 0; ALUOp = 3'b111 zero-extended; IllegalCount = 0; load counter cnt = 0. Takes effect immediately, including mid-load.
- InstrReady = (cnt==0) && !Flush. Accept = InstrValid && InstrReady.
- Accept: the decoded bundle is registered at the next edge, CtrlValid=1 (latency 1). Absent accept, Flush or load stretch: CtrlValid=0 and all write strobes (RegWrite, MemWrite) = 0.
- Decode table (unlisted fields take defaults RegDst 0, Branch 0, MemWrite 0, ALUSrc 0, RegWrite 1, MemtoReg 0, ALUOp 111, ImmLoad 0, Parity 0):
  - 0000 load: ALUOp 110, MemtoReg 1, RegDst 1
  - 0001 store: ALUOp 111, RegWrite 0, MemWrite 1, RegDst 1
  - 0010 xor: ALUOp 010, RegDst 1
  - 0011 bne: ALUOp 011, Branch 1, RegWrite 0, RegDst 1
  - 0100 add: ALUOp 001, ALUSrc 1
  - 0101 mov: ALUOp 000, RegDst 1
  - 0110 lshift: ALUOp 100, ALUSrc 1
  - 0111 rshift: ALUOp 101, ALUSrc 1
  - 1000 loadi: ALUOp 111, ALUSrc 1, ImmLoad 1
  - 1001 pari: ALUOp 111, Parity 1, RegDst 1
  - 1010–1111 (and any nonzero high bits): Illegal 1, RegWrite 0, MemWrite 0, Branch 0; IllegalCount increments, saturates at 2^CNTW-1.
- Load stretch:
  - On load accept, cnt = LOAD_LAT-1 and Busy = (cnt!=0).
  - The bundle is held with CtrlValid=1 for LOAD_LAT cycles; RegWrite=1 only in the final cycle (cnt==0), 0 in the earlier cycles.
  - cnt decrements each cycle; InstrReady stays low until cnt==0.
  - LOAD_LAT=1 gives single-cycle behaviour.
- Flush (priority over accept and stretch): at the next edge CtrlValid=0, cnt=0, Busy=0, write strobes 0. Instr offered in the flush cycle is not accepted (InstrReady=0). IllegalCount is unaffected by flush.
- Back-to-back: a new accept in the final load cycle is allowed; the new bundle replaces it at the next edge.

Test Plan:
- Reset then add (Instr=9'b0100_00011, InstrValid=1) -> next cycle CtrlValid=1, ALUOp=001, ALUSrc=1, RegWrite=1; InstrReady=1 throughout.
- Load with LOAD_LAT=3 -> CtrlValid=1 for 3 cycles, MemtoReg=1, RegWrite=0,0,1, Busy=1,1,0, InstrReady low for 2 cycles; following xor emitted in cycle 4.
- Flush asserted during the 2nd load cycle -> next cycle CtrlValid=0, RegWrite=0, Busy=0, cnt=0; a store offered in the flush cycle is dropped (InstrReady=0).
- Opcodes 1010..1111 streamed, then 300 illegals with CNTW=8 -> each gives Illegal=1, RegWrite=0, MemWrite=0; IllegalCount=6, then saturates at 255.
- Reset_n pulled low mid-load -> outputs cleared immediately, asynchronously; after release the first accept decodes normally with latency 1.
- loadi and pari -> ImmLoad=1, ALUSrc=1, RegWrite=1 for loadi; Parity=1, RegDst=1 for pari; bne -> Branch=1, RegWrite=0, ALUOp=011.

Source files
------------

// File: rtl/pipelined_control_if.sv
// Fetch/datapath-facing bundle of the pipelined control decoder.
// The master is the fetch/datapath side; the slave is the decoder itself.
interface pipelined_control_if #(
    parameter int MCODEBITS = 9,
    parameter int OPWIDTH   = 3,
    parameter int CNTW      = 8
) ();

    logic [MCODEBITS-1:0] Instr;
    logic                 InstrValid;
    logic                 InstrReady;
    logic                 Flush;

    logic                 CtrlValid;
    logic                 RegDst;
    logic                 Branch;
    logic                 MemtoReg;
    logic                 MemWrite;
    logic                 ALUSrc;
    logic                 RegWrite;
    logic                 ImmLoad;
    logic                 Parity;
    logic [OPWIDTH-1:0]   ALUOp;
    logic                 Illegal;
    logic                 Busy;
    logic [CNTW-1:0]      IllegalCount;

    modport master (
        output Instr, InstrValid, Flush,
        input  InstrReady, CtrlValid, RegDst, Branch, MemtoReg, MemWrite,
               ALUSrc, RegWrite, ImmLoad, Parity, ALUOp, Illegal, Busy,
               IllegalCount
    );

    modport slave (
        input  Instr, InstrValid, Flush,
        output InstrReady, CtrlValid, RegDst, Branch, MemtoReg, MemWrite,
               ALUSrc, RegWrite, ImmLoad, Parity, ALUOp, Illegal, Busy,
               IllegalCount
    );

endinterface

// File: rtl/pipelined_control.sv
// Registered, handshaked instruction decoder: one word in per cycle, control bundle out one cycle later.
// Loads are held for LOAD_LAT cycles, Flush kills the held bundle, illegal opcodes are counted.
module pipelined_control #(
    parameter int MCODEBITS  = 9,
    parameter int OPCODEBITS = 4,
    parameter int OPWIDTH    = 3,
    parameter int LOAD_LAT   = 2,
    parameter int CNTW       = 8
) (
    input  logic                Clk,
    input  logic                Reset_n,
    pipelined_control_if.slave  bus
);

    localparam logic [3:0] CNT_INIT = 4'(LOAD_LAT - 1);

    logic [OPCODEBITS-1:0] opcode;
    logic [3:0]            op_low;
    logic                  op_high_nz;
    logic                  accept;
    logic [3:0]            cnt;
    logic                  unused_operand;

    logic               dec_reg_dst;
    logic               dec_branch;
    logic               dec_mem_to_reg;
    logic               dec_mem_write;
    logic               dec_alu_src;
    logic               dec_reg_write;
    logic               dec_imm_load;
    logic               dec_parity;
    logic [OPWIDTH-1:0] dec_alu_op;
    logic               dec_illegal;
    logic               dec_load;

    assign opcode         = bus.Instr[MCODEBITS-1 -: OPCODEBITS];
    assign op_low         = opcode[3:0];
    assign op_high_nz     = (opcode >> 4) != '0;
    assign unused_operand = ^bus.Instr[MCODEBITS-OPCODEBITS-1:0];

    assign bus.InstrReady = (cnt == 4'd0) && !bus.Flush;
    assign accept         = bus.InstrValid && bus.InstrReady;
    assign bus.Busy       = (cnt != 4'd0);

    always_comb begin
        dec_reg_dst    = 1'b0;
        dec_branch     = 1'b0;
        dec_mem_to_reg = 1'b0;
        dec_mem_write  = 1'b0;
        dec_alu_src    = 1'b0;
        dec_reg_write  = 1'b1;
        dec_imm_load   = 1'b0;
        dec_parity     = 1'b0;
        dec_alu_op     = OPWIDTH'(3'b111);
        dec_illegal    = 1'b0;
        dec_load       = 1'b0;
        if (op_high_nz) begin
            dec_illegal   = 1'b1;
            dec_reg_write = 1'b0;
        end else begin
            case (op_low)
                4'b0000: begin
                    dec_load       = 1'b1;
                    dec_alu_op     = OPWIDTH'(3'b110);
                    dec_mem_to_reg = 1'b1;
                    dec_reg_dst    = 1'b1;
                end
                4'b0001: begin
                    dec_reg_write = 1'b0;
                    dec_mem_write = 1'b1;
                    dec_reg_dst   = 1'b1;
                end
                4'b0010: begin
                    dec_alu_op  = OPWIDTH'(3'b010);
                    dec_reg_dst = 1'b1;
                end
                4'b0011: begin
                    dec_alu_op    = OPWIDTH'(3'b011);
                    dec_branch    = 1'b1;
                    dec_reg_write = 1'b0;
                    dec_reg_dst   = 1'b1;
                end
                4'b0100: begin
                    dec_alu_op  = OPWIDTH'(3'b001);
                    dec_alu_src = 1'b1;
                end
                4'b0101: begin
                    dec_alu_op  = OPWIDTH'(3'b000);
                    dec_reg_dst = 1'b1;
                end
                4'b0110: begin
                    dec_alu_op  = OPWIDTH'(3'b100);
                    dec_alu_src = 1'b1;
                end
                4'b0111: begin
                    dec_alu_op  = OPWIDTH'(3'b101);
                    dec_alu_src = 1'b1;
                end
                4'b1000: begin
                    dec_alu_src  = 1'b1;
                    dec_imm_load = 1'b1;
                end
                4'b1001: begin
                    dec_parity  = 1'b1;
                    dec_reg_dst = 1'b1;
                end
                default: begin
                    dec_illegal   = 1'b1;
                    dec_reg_write = 1'b0;
                end
            endcase
        end
    end

    // Flush beats accept beats load stretch; cnt counts the remaining held cycles of a load.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bus.CtrlValid    <= 1'b0;
            bus.RegDst       <= 1'b0;
            bus.Branch       <= 1'b0;
            bus.MemtoReg     <= 1'b0;
            bus.MemWrite     <= 1'b0;
            bus.ALUSrc       <= 1'b0;
            bus.RegWrite     <= 1'b0;
            bus.ImmLoad      <= 1'b0;
            bus.Parity       <= 1'b0;
            bus.ALUOp        <= OPWIDTH'(3'b111);
            bus.Illegal      <= 1'b0;
            bus.IllegalCount <= '0;
            cnt              <= 4'd0;
        end else begin
            if (accept && dec_illegal && (bus.IllegalCount != '1))
                bus.IllegalCount <= bus.IllegalCount + CNTW'(1);

            if (bus.Flush) begin
                bus.CtrlValid <= 1'b0;
                bus.RegWrite  <= 1'b0;
                bus.MemWrite  <= 1'b0;
                cnt           <= 4'd0;
            end else if (accept) begin
                bus.CtrlValid <= 1'b1;
                bus.RegDst    <= dec_reg_dst;
                bus.Branch    <= dec_branch;
                bus.MemtoReg  <= dec_mem_to_reg;
                bus.MemWrite  <= dec_mem_write;
                bus.ALUSrc    <= dec_alu_src;
                bus.RegWrite  <= dec_reg_write && !(dec_load && (LOAD_LAT > 1));
                bus.ImmLoad   <= dec_imm_load;
                bus.Parity    <= dec_parity;
                bus.ALUOp     <= dec_alu_op;
                bus.Illegal   <= dec_illegal;
                cnt           <= dec_load ? CNT_INIT : 4'd0;
            end else if (cnt != 4'd0) begin
                // Load write-back fires only in the last held cycle.
                cnt          <= cnt - 4'd1;
                bus.RegWrite <= (cnt == 4'd1);
            end else begin
                bus.CtrlValid <= 1'b0;
                bus.RegWrite  <= 1'b0;
                bus.MemWrite  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pipelined_control.sv
// Randomized self-checking bench for pipelined_control against a queue-based schedule model.
// Directed phases pin the model with literal expectations before the random phase.
module tb_pipelined_control;

    localparam int LAT = 3;

    typedef struct packed {
        logic       ctrl_valid;
        logic       reg_dst;
        logic       branch;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic       imm_load;
        logic       parity;
        logic       illegal;
        logic [2:0] alu_op;
    } bundle_t;

    logic Clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 Clk = ~Clk;

    pipelined_control_if #(.MCODEBITS(9), .OPWIDTH(3), .CNTW(8)) bus ();

    pipelined_control #(
        .MCODEBITS(9), .OPCODEBITS(4), .OPWIDTH(3), .LOAD_LAT(LAT), .CNTW(8)
    ) dut (
        .Clk(Clk),
        .Reset_n(rst_n),
        .bus(bus)
    );

    int      nChecks = 0;
    int      nPass = 0;
    bit      checking = 1'b0;
    bundle_t expCur;
    bundle_t pending[$];
    int      expCount = 0;

    function automatic bundle_t decodeRef(logic [8:0] w);
        bundle_t    b;
        logic [3:0] op;
        op = w[8:5];
        b = '0;
        b.ctrl_valid = 1'b1;
        b.reg_write  = 1'b1;
        b.alu_op     = 3'b111;
        case (op)
            4'h0: begin b.alu_op = 3'b110; b.mem_to_reg = 1'b1; b.reg_dst = 1'b1; end
            4'h1: begin b.reg_write = 1'b0; b.mem_write = 1'b1; b.reg_dst = 1'b1; end
            4'h2: begin b.alu_op = 3'b010; b.reg_dst = 1'b1; end
            4'h3: begin b.alu_op = 3'b011; b.branch = 1'b1; b.reg_write = 1'b0; b.reg_dst = 1'b1; end
            4'h4: begin b.alu_op = 3'b001; b.alu_src = 1'b1; end
            4'h5: begin b.alu_op = 3'b000; b.reg_dst = 1'b1; end
            4'h6: begin b.alu_op = 3'b100; b.alu_src = 1'b1; end
            4'h7: begin b.alu_op = 3'b101; b.alu_src = 1'b1; end
            4'h8: begin b.alu_src = 1'b1; b.imm_load = 1'b1; end
            4'h9: begin b.parity = 1'b1; b.reg_dst = 1'b1; end
            default: begin b.illegal = 1'b1; b.reg_write = 1'b0; end
        endcase
        return b;
    endfunction

    function automatic logic [8:0] mk(logic [3:0] op);
        logic [4:0] operand;
        operand = 5'($urandom);
        return {op, operand};
    endfunction

    task automatic resetModel();
        pending.delete();
        expCur = '0;
        expCur.alu_op = 3'b111;
        expCount = 0;
    endtask

    // Every load becomes LAT scheduled output cycles; a flush simply discards the schedule.
    task automatic advanceModel(logic [8:0] w, logic v, logic f);
        bundle_t b;
        bundle_t held;
        if (f) begin
            pending.delete();
            expCur.ctrl_valid = 1'b0;
            expCur.reg_write  = 1'b0;
            expCur.mem_write  = 1'b0;
        end else if (v && pending.size() == 0) begin
            b = decodeRef(w);
            if (b.illegal && expCount < 255) expCount++;
            if (w[8:5] == 4'h0) begin
                for (int i = 0; i < LAT; i++) begin
                    held = b;
                    held.reg_write = (i == LAT - 1);
                    pending.push_back(held);
                end
                expCur = pending.pop_front();
            end else begin
                expCur = b;
            end
        end else if (pending.size() != 0) begin
            expCur = pending.pop_front();
        end else begin
            expCur.ctrl_valid = 1'b0;
            expCur.reg_write  = 1'b0;
            expCur.mem_write  = 1'b0;
        end
    endtask

    task automatic checkField(string name, logic [31:0] act, logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    task automatic checkOutput();
        checkField("CtrlValid", 32'(bus.CtrlValid), 32'(expCur.ctrl_valid));
        checkField("RegWrite", 32'(bus.RegWrite), 32'(expCur.reg_write));
        checkField("MemWrite", 32'(bus.MemWrite), 32'(expCur.mem_write));
        checkField("Busy", 32'(bus.Busy), 32'(pending.size() != 0));
        checkField("InstrReady", 32'(bus.InstrReady), 32'((pending.size() == 0) && !bus.Flush));
        checkField("IllegalCount", 32'(bus.IllegalCount), 32'(expCount));
        if (expCur.ctrl_valid) begin
            checkField("RegDst", 32'(bus.RegDst), 32'(expCur.reg_dst));
            checkField("Branch", 32'(bus.Branch), 32'(expCur.branch));
            checkField("MemtoReg", 32'(bus.MemtoReg), 32'(expCur.mem_to_reg));
            checkField("ALUSrc", 32'(bus.ALUSrc), 32'(expCur.alu_src));
            checkField("ImmLoad", 32'(bus.ImmLoad), 32'(expCur.imm_load));
            checkField("Parity", 32'(bus.Parity), 32'(expCur.parity));
            checkField("Illegal", 32'(bus.Illegal), 32'(expCur.illegal));
            checkField("ALUOp", 32'(bus.ALUOp), 32'(expCur.alu_op));
        end
    endtask

    always @(negedge Clk) if (checking) checkOutput();

    task automatic applyStimulus(logic [8:0] w, logic v, logic f);
        bus.Instr      = w;
        bus.InstrValid = v;
        bus.Flush      = f;
        @(posedge Clk);
        advanceModel(w, v, f);
        #1;
    endtask

    initial begin
        bus.Instr      = '0;
        bus.InstrValid = 1'b0;
        bus.Flush      = 1'b0;
        resetModel();
        repeat (2) @(posedge Clk);
        #1;
        rst_n = 1'b1;
        #1;
        checkField("reset CtrlValid", 32'(bus.CtrlValid), 32'd0);
        checkField("reset ALUOp", 32'(bus.ALUOp), 32'd7);
        checkField("reset IllegalCount", 32'(bus.IllegalCount), 32'd0);
        checkField("reset InstrReady", 32'(bus.InstrReady), 32'd1);
        checking = 1'b1;

        applyStimulus(9'b0100_00011, 1'b1, 1'b0);
        checkField("add CtrlValid", 32'(bus.CtrlValid), 32'd1);
        checkField("add ALUOp", 32'(bus.ALUOp), 32'd1);
        checkField("add ALUSrc", 32'(bus.ALUSrc), 32'd1);
        checkField("add RegWrite", 32'(bus.RegWrite), 32'd1);

        applyStimulus(mk(4'h0), 1'b1, 1'b0);
        checkField("load1 MemtoReg", 32'(bus.MemtoReg), 32'd1);
        checkField("load1 RegWrite", 32'(bus.RegWrite), 32'd0);
        checkField("load1 Busy", 32'(bus.Busy), 32'd1);
        applyStimulus(mk(4'h2), 1'b1, 1'b0);
        checkField("load2 Busy", 32'(bus.Busy), 32'd1);
        applyStimulus(mk(4'h2), 1'b1, 1'b0);
        checkField("load3 RegWrite", 32'(bus.RegWrite), 32'd1);
        checkField("load3 Busy", 32'(bus.Busy), 32'd0);
        checkField("load3 CtrlValid", 32'(bus.CtrlValid), 32'd1);
        applyStimulus(mk(4'h2), 1'b1, 1'b0);
        checkField("xor after load ALUOp", 32'(bus.ALUOp), 32'd2);

        applyStimulus(mk(4'h0), 1'b1, 1'b0);
        applyStimulus(mk(4'h5), 1'b0, 1'b0);
        bus.Instr      = mk(4'h1);
        bus.InstrValid = 1'b1;
        bus.Flush      = 1'b1;
        #1;
        checkField("flush InstrReady", 32'(bus.InstrReady), 32'd0);
        applyStimulus(bus.Instr, 1'b1, 1'b1);
        checkField("flush CtrlValid", 32'(bus.CtrlValid), 32'd0);
        checkField("flush Busy", 32'(bus.Busy), 32'd0);
        checkField("flush MemWrite", 32'(bus.MemWrite), 32'd0);
        applyStimulus(mk(4'h5), 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) applyStimulus(mk(4'(10 + i)), 1'b1, 1'b0);
        checkField("illegal count 6", 32'(bus.IllegalCount), 32'd6);
        for (int i = 0; i < 300; i++) applyStimulus(mk(4'(10 + (i % 6))), 1'b1, 1'b0);
        checkField("illegal saturate", 32'(bus.IllegalCount), 32'd255);

        applyStimulus(mk(4'h8), 1'b1, 1'b0);
        checkField("loadi ImmLoad", 32'(bus.ImmLoad), 32'd1);
        checkField("loadi RegWrite", 32'(bus.RegWrite), 32'd1);
        applyStimulus(mk(4'h9), 1'b1, 1'b0);
        checkField("pari Parity", 32'(bus.Parity), 32'd1);
        checkField("pari RegDst", 32'(bus.RegDst), 32'd1);
        applyStimulus(mk(4'h3), 1'b1, 1'b0);
        checkField("bne Branch", 32'(bus.Branch), 32'd1);
        checkField("bne RegWrite", 32'(bus.RegWrite), 32'd0);
        checkField("bne ALUOp", 32'(bus.ALUOp), 32'd3);

        // Asynchronous reset in the middle of a load, away from any clock edge.
        applyStimulus(mk(4'h0), 1'b1, 1'b0);
        bus.InstrValid = 1'b0;
        #2;
        checking = 1'b0;
        rst_n = 1'b0;
        #1;
        checkField("async CtrlValid", 32'(bus.CtrlValid), 32'd0);
        checkField("async Busy", 32'(bus.Busy), 32'd0);
        checkField("async MemtoReg", 32'(bus.MemtoReg), 32'd0);
        checkField("async ALUOp", 32'(bus.ALUOp), 32'd7);
        checkField("async IllegalCount", 32'(bus.IllegalCount), 32'd0);
        resetModel();
        @(posedge Clk);
        #1;
        rst_n = 1'b1;
        checking = 1'b1;
        applyStimulus(mk(4'h5), 1'b1, 1'b0);
        checkField("post-reset CtrlValid", 32'(bus.CtrlValid), 32'd1);
        checkField("post-reset ALUOp", 32'(bus.ALUOp), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            applyStimulus(mk(4'($urandom_range(0, 15))),
                          1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 9) == 0));
        end

        applyStimulus(mk(4'h5), 1'b0, 1'b0);
        checking = 1'b0;
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
